// File: rtl/upower_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the uPower datapath.
// Optional performance counters (retired_cnt, stall_cnt) are built when SEQ_PERF_CNT_EN is defined.
module upower_multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        cond_taken,
  input  logic        mem_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_read,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [2:0]  state,
  output logic        busy,
  output logic        retire,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        mem_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_XALU  = 3'd1,
    C_DALU  = 3'd2,
    C_LOAD  = 3'd3,
    C_STORE = 3'd4,
    C_BR    = 3'd5,
    C_BC    = 3'd6,
    C_ILL   = 3'd7
  } cls_e;

  state_e            state_q, state_d;
  cls_e              cls_q, op_cls;
  logic [TMO_W-1:0]  tmo_q;
  logic              wait_cyc;
  logic              tmo_exp;

  // Primary-opcode to instruction-class map
  function automatic cls_e decode_op(input logic [5:0] op);
    case (op)
      6'd31:                                decode_op = C_XALU;
      6'd14, 6'd15, 6'd24, 6'd26, 6'd28:    decode_op = C_DALU;
      6'd32, 6'd34, 6'd40, 6'd42, 6'd58:    decode_op = C_LOAD;
      6'd36, 6'd37, 6'd38, 6'd44, 6'd62:    decode_op = C_STORE;
      6'd18:                                decode_op = C_BR;
      6'd19:                                decode_op = C_BC;
      default:                              decode_op = C_ILL;
    endcase
  endfunction

  assign op_cls   = decode_op(opcode);
  assign wait_cyc = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack;
  assign tmo_exp  = (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

  // State, latched class and memory-wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= op_cls;
      tmo_q <= wait_cyc ? tmo_q + TMO_W'(1) : '0;
    end
  end

  // Next state and per-cycle datapath strobes
  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_read   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    retire     = 1'b0;
    mem_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo_exp) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        reg_read = (op_cls != C_BR);
        case (op_cls)
          C_BR: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            retire   = 1'b1;
            state_d  = run ? S_FETCH : S_IDLE;
          end
          C_ILL:   state_d = S_ERR;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_src = (cls_q == C_DALU) || (cls_q == C_LOAD) || (cls_q == C_STORE);
        reg_dst = (cls_q == C_XALU);
        case (cls_q)
          C_XALU, C_DALU:  state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BC: begin
            pc_write = cond_taken;
            pc_src   = 1'b1;
            retire   = 1'b1;
            state_d  = run ? S_FETCH : S_IDLE;
          end
          default:         state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls_q == C_LOAD);
        mem_write = (cls_q == C_STORE);
        if (mem_ack) begin
          if (cls_q == C_STORE) begin
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_exp) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LOAD);
        reg_dst    = (cls_q == C_XALU);
        retire     = 1'b1;
        state_d    = run ? S_FETCH : S_IDLE;
      end
      S_ERR: begin
        mem_err = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;
  assign busy  = (state_q != S_IDLE) && (state_q != S_ERR);

`ifdef SEQ_PERF_CNT_EN
  // Retired-instruction and memory-stall counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire)   retired_cnt <= retired_cnt + 32'd1;
      if (wait_cyc) stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_upower_multicycle_sequencer.sv
// Bench for upower_multicycle_sequencer: a per-cycle expected trace is built from
// instruction-level rules, then driven and compared cycle by cycle.
module tb_upower_multicycle_sequencer;

  localparam int TMO = 15;
  localparam logic [9:0] MR  = 10'b10_0000_0000;
  localparam logic [9:0] MW  = 10'b01_0000_0000;
  localparam logic [9:0] IRW = 10'b00_1000_0000;
  localparam logic [9:0] PCW = 10'b00_0100_0000;
  localparam logic [9:0] PCS = 10'b00_0010_0000;
  localparam logic [9:0] RR  = 10'b00_0001_0000;
  localparam logic [9:0] RW  = 10'b00_0000_1000;
  localparam logic [9:0] RD  = 10'b00_0000_0100;
  localparam logic [9:0] M2R = 10'b00_0000_0010;
  localparam logic [9:0] AS  = 10'b00_0000_0001;
  localparam logic [5:0] NOP = 6'd63;

  logic clk, rst_n, run, cond_taken, mem_ack;
  logic [5:0] opcode;
  logic mem_read, mem_write, ir_write, pc_write, pc_src, reg_read, reg_write;
  logic reg_dst, mem_to_reg, alu_src, busy, retire, mem_err;
  logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  upower_multicycle_sequencer #(.MEM_TIMEOUT(15), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .cond_taken(cond_taken),
    .mem_ack(mem_ack), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_read(reg_read), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .state(state),
    .busy(busy), .retire(retire),
`ifdef SEQ_PERF_CNT_EN
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
    .mem_err(mem_err)
  );

  typedef struct {
    logic       rstn;
    logic       run;
    logic [5:0] op;
    logic       cond;
    logic       ack;
    logic [2:0] st;
    logic [9:0] ctl;
    logic       ret;
  } rec_t;

  rec_t tr[$];
  int   start_q[$];
  int   ret_idx[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 0 XALU, 1 DALU, 2 LOAD, 3 STORE, 4 BR, 5 BC, 6 illegal
  function automatic int cls(input logic [5:0] op);
    if (op == 6'd31) return 0;
    if (op inside {6'd14, 6'd15, 6'd24, 6'd26, 6'd28}) return 1;
    if (op inside {6'd32, 6'd34, 6'd40, 6'd42, 6'd58}) return 2;
    if (op inside {6'd36, 6'd37, 6'd38, 6'd44, 6'd62}) return 3;
    if (op == 6'd18) return 4;
    if (op == 6'd19) return 5;
    return 6;
  endfunction

  task automatic cyc(input logic [2:0] st, input logic [9:0] ctl, input logic ret,
                     input logic ack, input logic [5:0] op, input logic rn, input logic cond);
    rec_t r;
    r.rstn = 1'b1; r.run = rn; r.op = op; r.cond = cond; r.ack = ack;
    r.st = st; r.ctl = ctl; r.ret = ret;
    tr.push_back(r);
  endtask

  task automatic rst_cyc();
    rec_t r;
    r.rstn = 1'b0; r.run = 1'b0; r.op = NOP; r.cond = 1'b0; r.ack = 1'b0;
    r.st = 3'd0; r.ctl = '0; r.ret = 1'b0;
    tr.push_back(r);
  endtask

  task automatic idle(input logic rn);
    cyc(3'd0, '0, 1'b0, 1'b0, NOP, rn, 1'b0);
  endtask

  task automatic err_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(3'd6, '0, 1'b0, 1'b1, NOP, 1'b1, 1'b1);
  endtask

  // One instruction: fd/md are wait cycles before the ack in FETCH/MEM;
  // run_end is the run level from EXEC onward (and in a BR decode).
  task automatic instr(input logic [5:0] op, input int fd, input int md, input logic cond,
                       input logic run_end, output logic err);
    int k;
    logic [9:0] ex, mc;
    k = cls(op);
    err = 1'b0;
    for (int i = 0; i < fd && i < TMO; i++) cyc(3'd1, MR, 1'b0, 1'b0, NOP, 1'b1, cond);
    if (fd >= TMO) begin err = 1'b1; return; end
    cyc(3'd1, MR | IRW | PCW, 1'b0, 1'b1, NOP, 1'b1, cond);
    if (k == 4) begin
      cyc(3'd2, PCW | PCS, 1'b1, 1'b1, op, run_end, cond);
      return;
    end
    cyc(3'd2, RR, 1'b0, 1'b1, op, 1'b1, cond);
    if (k == 6) begin err = 1'b1; return; end
    ex = ((k == 1 || k == 2 || k == 3) ? AS : '0) | ((k == 0) ? RD : '0);
    if (k == 5) begin
      cyc(3'd3, ex | PCS | (cond ? PCW : '0), 1'b1, 1'b1, NOP, run_end, cond);
      return;
    end
    cyc(3'd3, ex, 1'b0, 1'b1, NOP, run_end, cond);
    if (k == 2 || k == 3) begin
      mc = (k == 2) ? MR : MW;
      for (int i = 0; i < md && i < TMO; i++) cyc(3'd4, mc, 1'b0, 1'b0, NOP, run_end, cond);
      if (md >= TMO) begin err = 1'b1; return; end
      cyc(3'd4, mc, (k == 3), 1'b1, NOP, run_end, cond);
      if (k == 3) return;
    end
    cyc(3'd5, RW | ((k == 2) ? M2R : '0) | ((k == 0) ? RD : '0), 1'b1, 1'b1, NOP, run_end, cond);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic err;
    int lat_lit [5];
    int exp_ret, exp_stall;
    logic [2:0] es;

    rst_n = 1'b0; run = 1'b0; opcode = NOP; cond_taken = 1'b0; mem_ack = 1'b0;
    lat_lit[0] = 5; lat_lit[1] = 6; lat_lit[2] = 5; lat_lit[3] = 4; lat_lit[4] = 3;
    exp_ret = 0; exp_stall = 0;

    rst_cyc(); rst_cyc();
    // Immediate-ack latency per class, each from IDLE
    start_q.push_back(tr.size()); idle(1'b1); instr(6'd31, 0, 0, 1'b1, 1'b0, err);
    start_q.push_back(tr.size()); idle(1'b1); instr(6'd32, 0, 0, 1'b1, 1'b0, err);
    start_q.push_back(tr.size()); idle(1'b1); instr(6'd36, 0, 0, 1'b1, 1'b0, err);
    start_q.push_back(tr.size()); idle(1'b1); instr(6'd19, 0, 0, 1'b1, 1'b0, err);
    start_q.push_back(tr.size()); idle(1'b1); instr(6'd18, 0, 0, 1'b1, 1'b0, err);
    // Back-to-back stream with varied ack delays; run dropped during a store's MEM
    idle(1'b1);
    instr(6'd31, 1, 0, 1'b1, 1'b1, err);
    instr(6'd32, 1, 3, 1'b1, 1'b1, err);
    instr(6'd19, 0, 0, 1'b0, 1'b1, err);
    instr(6'd19, 0, 0, 1'b1, 1'b1, err);
    instr(6'd14, 2, 0, 1'b0, 1'b1, err);
    instr(6'd62, 0, 0, 1'b1, 1'b1, err);
    instr(6'd58, 0, 1, 1'b0, 1'b1, err);
    instr(6'd18, 0, 0, 1'b0, 1'b1, err);
    instr(6'd36, 0, 2, 1'b0, 1'b0, err);
    idle(1'b0); idle(1'b0);
    // Ack on the last allowed wait cycle beats the timeout
    idle(1'b1); instr(6'd24, TMO - 1, 0, 1'b0, 1'b0, err); idle(1'b0);
    // Illegal opcode
    idle(1'b1); instr(6'd0, 0, 0, 1'b0, 1'b1, err); err_cycles(3); rst_cyc(); idle(1'b0);
    // Reset in the middle of a fetch
    idle(1'b1);
    cyc(3'd1, MR, 1'b0, 1'b0, NOP, 1'b1, 1'b0);
    cyc(3'd1, MR, 1'b0, 1'b0, NOP, 1'b1, 1'b0);
    rst_cyc(); idle(1'b0);
    // Fetch timeout, then load-MEM timeout
    idle(1'b1); instr(6'd31, TMO, 0, 1'b0, 1'b1, err); err_cycles(4); rst_cyc(); idle(1'b0);
    idle(1'b1); instr(6'd40, 0, TMO, 1'b0, 1'b1, err); err_cycles(2); rst_cyc(); idle(1'b0);

    for (int i = 0; i < tr.size(); i++) begin
      @(negedge clk);
      rst_n = tr[i].rstn; run = tr[i].run; opcode = tr[i].op;
      cond_taken = tr[i].cond; mem_ack = tr[i].ack;
      #1;
      es = tr[i].st;
      if (!tr[i].rstn) begin exp_ret = 0; exp_stall = 0; end
      check("state", i, 32'(state), 32'(es));
      check("strobes", i,
            32'({mem_read, mem_write, ir_write, pc_write, pc_src, reg_read, reg_write,
                 reg_dst, mem_to_reg, alu_src}), 32'(tr[i].ctl));
      check("busy_retire_err", i, 32'({busy, retire, mem_err}),
            32'({(es != 3'd0) && (es != 3'd6), tr[i].ret, es == 3'd6}));
`ifdef SEQ_PERF_CNT_EN
      check("retired_cnt", i, retired_cnt, 32'(exp_ret));
      check("stall_cnt", i, stall_cnt, 32'(exp_stall));
`endif
      if (retire === 1'b1) ret_idx.push_back(i);
      if (tr[i].rstn) begin
        if (tr[i].ret) exp_ret++;
        if ((es == 3'd1 || es == 3'd4) && !tr[i].ack) exp_stall++;
      end
    end

    check("retire_total", -1, 32'(ret_idx.size()), 32'd15);
    for (int j = 0; j < 5; j++)
      check("latency", j, (j < ret_idx.size()) ? 32'(ret_idx[j] - start_q[j] + 1) : 32'hFFFF_FFFF,
            32'(lat_lit[j]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/upower_multicycle_sequencer.md
Name: upower_multicycle_sequencer

Overview:
- Multi-cycle FSM sequencer for the uPower datapath.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the per-cycle datapath control strobes from the primary opcode.
- Handshakes with a shared instruction/data memory port.
- Sits between the instruction register/opcode field and the PC, register file, ALU-mux and memory enables.

Parameters:
- MEM_TIMEOUT, 15: max wait cycles for mem_ack before error.
- TMO_W, 4: width of timeout counter. Must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  enable instruction sequencing.
- opcode  in  6  primary opcode from instruction register.
- cond_taken  in  1  branch condition result (opcode 19).
- mem_ack  in  1  memory access complete, one-cycle pulse.
- mem_read  out  1  memory read request (fetch or load).
- mem_write  out  1  memory write request (store).
- ir_write  out  1  latch fetched instruction.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg_read  out  1  register file read enable.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination from X/XO field.
- mem_to_reg  out  1  write-back data from memory.
- alu_src  out  1  ALU operand B is immediate.
- state  out  3  current FSM state.
- busy  out  1  state not IDLE and not ERR.
- retire  out  1  one-cycle pulse per completed instruction.
- mem_err  out  1  sticky error: timeout or illegal opcode.

Behaviour:
- Reset: state=IDLE (0), all outputs 0, timeout counter 0, latched class cleared.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
- Opcode classes, latched in DECODE:
  - XALU: 31.
  - DALU: 14, 15, 24, 26, 28.
  - LOAD: 32, 34, 40, 42, 58.
  - STORE: 36, 37, 38, 44, 62.
  - BR: 18.
  - BC: 19.
  - Any other opcode: ILLEGAL.
- IDLE: run=1 -> FETCH.
- FETCH: mem_read=1 held until mem_ack. On the ack cycle: ir_write=1, pc_write=1, pc_src=0, -> DECODE.
- DECODE:
  - reg_read=1 for every class except BR.
  - BR: pc_write=1, pc_src=1, retire=1, -> FETCH (run=1) or IDLE (run=0).
  - ILLEGAL: -> ERR.
  - Others: -> EXEC.
- EXEC:
  - alu_src=1 for DALU/LOAD/STORE; reg_dst=1 for XALU.
  - XALU/DALU -> WB.
  - LOAD/STORE -> MEM.
  - BC: pc_write=cond_taken, pc_src=1, retire=1, -> FETCH/IDLE per run.
- MEM:
  - LOAD: mem_read=1; on ack -> WB.
  - STORE: mem_write=1; on ack retire=1, -> FETCH/IDLE per run.
- WB: reg_write=1; mem_to_reg=1 for LOAD; reg_dst=1 for XALU; retire=1; -> FETCH/IDLE per run.
- ERR: all strobes 0, mem_err=1, busy=0. Exit only via rst_n.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each wait cycle without ack.
  - Reaching MEM_TIMEOUT with no ack -> ERR. An ack on that same cycle wins.
- Control outputs are combinational from state, latched class, mem_ack and cond_taken only. The opcode input is sampled only in DECODE.
- run deasserted mid-instruction: the current instruction completes, then IDLE. No instruction is aborted.
- mem_ack outside FETCH/MEM is ignored.
- rst_n asserted mid-access: immediate IDLE, strobes drop without waiting for ack.
- Latency with immediate ack:
  - ALU: 5 cycles.
  - Load: 6.
  - Store: 5.
  - BC: 4.
  - BR: 3.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- When defined, adds two outputs:
  - retired_cnt, 32 bits: increments on retire.
  - stall_cnt, 32 bits: increments on each FETCH/MEM cycle without mem_ack.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, neither port nor its counter exists. All other behaviour is identical.

Test Plan:
- Reset mid-FETCH with mem_read=1 -> next cycle state=0, mem_read=0, mem_err=0.
- run=1, opcode=31, ack 1 cycle after each request -> states 1,2,3,5. reg_dst=1 in WB, reg_write=1 for exactly 1 cycle, retire pulse, back to FETCH.
- opcode=32 (load), ack delayed 3 cycles in MEM -> mem_read held 4 cycles. WB has mem_to_reg=1, reg_write=1.
- opcode=19, with cond_taken=0 then 1 -> pc_write=0 then pc_write=1/pc_src=1 in EXEC. Both retire.
- No mem_ack in FETCH with MEM_TIMEOUT=15 -> ERR after 15 wait cycles, mem_err=1 until rst_n. Separately, opcode=0 -> ERR from DECODE.
- run dropped during MEM of store (opcode 36) -> store completes on ack, retire=1, state=IDLE. With SEQ_PERF_CNT_EN, retired_cnt increments by 1.
